seq_comparator: RTL and testbench
=================================

Name: seq_comparator

Overview:
- Parametrised, multi-cycle magnitude/equality comparator for the ALU comparison group; next generation of the fixed 20-bit less-than unit.
- Compares `register_A` and `register_B` MSB-first, `SLICE` bits per cycle, and stops early at the first differing slice.
- Supports signed or unsigned operands and six predicates. Produces `sign_flag` (A<B), `zero_flag` (A==B) and a predicate `result`, with a start/ready/valid handshake toward the control unit.

Parameters:
- WIDTH, 20, operand width in bits.
- SLICE, 4, bits compared per cycle; WIDTH must be a multiple of SLICE (elaboration error otherwise).
- NSLICE, WIDTH/SLICE, derived; number of slices; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted when start && ready.
- op  input  3  predicate: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE; 6/7 reserved, evaluate as EQ.
- is_signed  input  1  1 = two's-complement compare.
- register_A  input  WIDTH  operand A; sampled only on accept.
- register_B  input  WIDTH  operand B; sampled only on accept.
- ready  output  1  high in IDLE and DONE.
- busy  output  1  high in BUSY.
- result_valid  output  1  one-cycle pulse in DONE.
- result  output  1  predicate outcome; held until the next accept.
- sign_flag  output  1  A<B under the selected signedness; held until the next accept.
- zero_flag  output  1  A==B; held until the next accept.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, slice index=0, operand registers=0.
  - result=0, sign_flag=0, zero_flag=0, result_valid=0.
  - ready=1, busy=0.
- FSM states IDLE, BUSY, DONE:
  - IDLE: on start, go to BUSY. Otherwise stay.
  - BUSY: ignores start. Each cycle, compare slice idx, where slice 0 = bits [WIDTH-1 -: SLICE].
    - If the slice differs, or idx==NSLICE-1: latch the flags, go to DONE.
    - Otherwise idx++.
  - DONE: result_valid=1 for one cycle. If start is asserted, accept the new operation and go to BUSY (back-to-back). Otherwise go to IDLE.
- Accept edge:
  - Capture operands, op and is_signed.
  - Set idx=0.
  - Clear result, sign_flag and zero_flag to 0.
- Signed mode: invert the MSB of both captured operands, then compare unsigned.
- Flag latch:
  - At the first differing slice: sign_flag = slice_A < slice_B, zero_flag = 0.
  - All slices equal: sign_flag=0, zero_flag=1.
  - result is derived as:
    - EQ = zero_flag
    - NE = !zero_flag
    - LT = sign_flag
    - LE = sign_flag | zero_flag
    - GT = !(sign_flag | zero_flag)
    - GE = !sign_flag
- Latency, counted in clock edges after the accept edge:
  - result_valid is high in the cycle after edge d+1, where d is the deciding slice index.
  - Minimum 1 cycle, maximum NSLICE. For the defaults, equal operands take 5 cycles.
- Operand inputs may change freely after accept; they do not affect the operation in flight.
- Reset mid-BUSY aborts immediately: no result_valid, all outputs return to reset values.

Decomposition:
- Shared package cmp_pkg:
  - op codes (CMP_EQ..CMP_GE);
  - state encoding (ST_IDLE, ST_BUSY, ST_DONE);
  - a function mapping (op, sign_flag, zero_flag) to result, reused by the future branch unit.
- One sub-module, cmp_slice: combinational SLICE-bit compare giving lt and eq outputs; instantiated once and fed by a slice mux.

Test Plan:
- Unsigned LT, decision in slice 0: A=20'hABCDE, B=20'h54321, op=LT, is_signed=0, start for 1 cycle.
  - Required: result_valid 1 cycle after accept; sign_flag=0, zero_flag=0, result=0.
- Same operands signed: A=20'hABCDE, B=20'h54321, is_signed=1, op=LT.
  - Required: sign_flag=1, result=1, latency 1.
- Swapped operands: A=20'h54321, B=20'hABCDE, unsigned, op=GE.
  - Required: sign_flag=1, result=0.
- Decision in last slice: A=20'h54320, B=20'h54321, op=LE.
  - Required: result_valid 5 cycles after accept; sign_flag=1, result=1.
- Equal operands: A=B=20'h0F0F0, op=NE.
  - Required: latency 5, zero_flag=1, result=0.
  - Then assert start in the DONE cycle with A=1, B=0, op=GT: accepted back-to-back; after the first differing slice (idx 4), result=1.
- Robustness: pulse start while busy and check it is ignored. Pull rst_n low mid-BUSY.
  - Required: outputs are at reset values within the same cycle; no result_valid appears afterwards.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared comparison definitions: predicate codes, FSM encoding and the
// predicate-from-flags mapping reused by the branch unit.
package cmp_pkg;

    localparam logic [2:0] CMP_EQ = 3'd0;
    localparam logic [2:0] CMP_NE = 3'd1;
    localparam logic [2:0] CMP_LT = 3'd2;
    localparam logic [2:0] CMP_LE = 3'd3;
    localparam logic [2:0] CMP_GT = 3'd4;
    localparam logic [2:0] CMP_GE = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_e;

    // Reserved codes 6/7 fall through to EQ.
    function automatic logic cmp_result(input logic [2:0] op,
                                        input logic      sign_f,
                                        input logic      zero_f);
        logic res;
        case (op)
            CMP_NE:  res = !zero_f;
            CMP_LT:  res = sign_f;
            CMP_LE:  res = sign_f | zero_f;
            CMP_GT:  res = !(sign_f | zero_f);
            CMP_GE:  res = !sign_f;
            default: res = zero_f;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned compare of one operand slice; zero latency.
module cmp_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_lt,
    output logic         o_eq
);

    assign o_lt = (i_a < i_b);
    assign o_eq = (i_a == i_b);

endmodule

// File: rtl/seq_comparator.sv
// MSB-first slice-serial comparator; result_valid 1..NSLICE cycles after accept,
// early exit on first differing slice. start is ignored while busy.
module seq_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] register_A,
    input  logic [WIDTH-1:0] register_B,
    output logic             ready,
    output logic             busy,
    output logic             result_valid,
    output logic             result,
    output logic             sign_flag,
    output logic             zero_flag
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("seq_comparator: WIDTH must be a multiple of SLICE");
    end

    cmp_state_e       r_state;
    cmp_state_e       w_state_nxt;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_result;
    logic             r_sign;
    logic             r_zero;

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic             w_lt;
    logic             w_eq;
    logic             w_last;
    logic             w_decide;
    logic             w_accept;
    logic [WIDTH-1:0] w_msb_flip;

    assign ready        = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign busy         = (r_state == ST_BUSY);
    assign result_valid = (r_state == ST_DONE);
    assign result       = r_result;
    assign sign_flag    = r_sign;
    assign zero_flag    = r_zero;

    assign w_accept   = start && ready;
    assign w_last     = (r_idx == IDXW'(NSLICE - 1));
    assign w_decide   = !w_eq || w_last;
    // Flipping the sign bits maps two's-complement order onto unsigned order.
    assign w_msb_flip = {is_signed, {(WIDTH-1){1'b0}}};

    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_sl = r_a[WIDTH-1-i*SLICE -: SLICE];
                w_b_sl = r_b[WIDTH-1-i*SLICE -: SLICE];
            end
        end
    end

    cmp_slice #(.W(SLICE)) u_slice (
        .i_a  (w_a_sl),
        .i_b  (w_b_sl),
        .o_lt (w_lt),
        .o_eq (w_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_decide) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = start ? ST_BUSY : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= CMP_EQ;
            r_result <= 1'b0;
            r_sign   <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_idx    <= '0;
            r_a      <= register_A ^ w_msb_flip;
            r_b      <= register_B ^ w_msb_flip;
            r_op     <= op;
            r_result <= 1'b0;
            r_sign   <= 1'b0;
            r_zero   <= 1'b0;
        end else if (r_state == ST_BUSY) begin
            if (w_decide) begin
                // w_lt is 0 when all slices matched, so it doubles as sign_flag.
                r_sign   <= w_lt;
                r_zero   <= w_eq;
                r_result <= cmp_result(r_op, w_lt, w_eq);
            end else begin
                r_idx <= r_idx + IDXW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_comparator.sv
// Directed plus randomized checks of seq_comparator against an arithmetic model.
module tb_seq_comparator;

    localparam int W      = 20;
    localparam int S      = 4;
    localparam int NSLICE = W / S;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic         is_signed;
    logic [W-1:0] register_A;
    logic [W-1:0] register_B;
    logic         ready;
    logic         busy;
    logic         result_valid;
    logic         result;
    logic         sign_flag;
    logic         zero_flag;

    int n_pass  = 0;
    int n_total = 0;

    logic e_res, e_sign, e_zero;

    seq_comparator #(.WIDTH(W), .SLICE(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .is_signed    (is_signed),
        .register_A   (register_A),
        .register_B   (register_B),
        .ready        (ready),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .sign_flag    (sign_flag),
        .zero_flag    (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: plain arithmetic compare; latency = index of first differing slice + 1.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                         input logic sg, output logic lt, output logic eq,
                         output logic res, output int lat);
        logic [W-1:0] smask;
        logic         found;
        smask = W'((1 << S) - 1);
        eq    = (a == b);
        lt    = sg ? ($signed(a) < $signed(b)) : (a < b);
        lat   = NSLICE;
        found = 1'b0;
        for (int i = 0; i < NSLICE; i++) begin
            if (!found && (((a >> (W - (i + 1) * S)) & smask) != ((b >> (W - (i + 1) * S)) & smask))) begin
                lat   = i + 1;
                found = 1'b1;
            end
        end
        case (o)
            3'd1:    res = !eq;
            3'd2:    res = lt;
            3'd3:    res = lt || eq;
            3'd4:    res = !lt && !eq;
            3'd5:    res = !lt;
            default: res = eq;
        endcase
    endtask

    // Enters from a cycle where ready is expected; returns in the DONE cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                          input logic sg, input logic poke);
        logic lt, eq, res;
        int   elat, lat;
        logic seen;
        model(a, b, o, sg, lt, eq, res, elat);
        chk("ready_pre", ready, 1);
        start = 1'b1; register_A = a; register_B = b; op = o; is_signed = sg;
        @(posedge clk); #1;
        start = poke;
        register_A = W'($urandom); register_B = W'($urandom);
        op = 3'($urandom); is_signed = 1'($urandom);
        chk("busy_acc", busy, 1);
        chk("vld_acc", result_valid, 0);
        chk("flags_clr", {result, sign_flag, zero_flag}, 0);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= NSLICE + 2 && !seen; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (result_valid) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        chk("latency", lat, elat);
        chk("sign_flag", sign_flag, lt);
        chk("zero_flag", zero_flag, eq);
        chk("result", result, res);
        e_res = res; e_sign = lt; e_zero = eq;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            chk("idle_vld", result_valid, 0);
            chk("idle_hold", {ready, result, sign_flag, zero_flag}, {1'b1, e_res, e_sign, e_zero});
        end
    endtask

    initial begin
        int           vld_after;
        logic [W-1:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; op = 3'd0; is_signed = 1'b0;
        register_A = '0; register_B = '0;
        e_res = 1'b0; e_sign = 1'b0; e_zero = 1'b0;
        #3;
        chk("rst_outs", {ready, busy, result_valid, result, sign_flag, zero_flag}, 6'b100000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        run_op(20'hABCDE, 20'h54321, 3'd2, 1'b0, 1'b0);
        idle(1);
        run_op(20'hABCDE, 20'h54321, 3'd2, 1'b1, 1'b0);
        idle(2);
        run_op(20'h54321, 20'hABCDE, 3'd5, 1'b0, 1'b0);
        idle(1);
        run_op(20'h54320, 20'h54321, 3'd3, 1'b0, 1'b0);
        idle(1);
        run_op(20'h0F0F0, 20'h0F0F0, 3'd1, 1'b0, 1'b0);
        run_op(20'h00001, 20'h00000, 3'd4, 1'b0, 1'b0);
        idle(1);

        // start pulsed during BUSY must not disturb the in-flight operation
        run_op(20'h12340, 20'h12345, 3'd0, 1'b0, 1'b1);
        idle(1);
        run_op(20'h80000, 20'h7FFFF, 3'd2, 1'b1, 1'b1);
        idle(1);

        // reset in the middle of a long operation
        start = 1'b1; register_A = 20'h33333; register_B = 20'h33333; op = 3'd0; is_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_mid", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", {ready, busy, result_valid, result, sign_flag, zero_flag}, 6'b100000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        vld_after = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (result_valid) vld_after++;
        end
        chk("no_vld_after_rst", vld_after, 0);
        chk("ready_after_rst", {ready, busy}, 2'b10);
        e_res = 1'b0; e_sign = 1'b0; e_zero = 1'b0;

        for (int t = 0; t < 60; t++) begin
            ra = W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = W'($urandom);
            else rb = ra ^ (W'($urandom) >> $urandom_range(0, W));
            run_op(ra, rb, 3'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
